// File: rtl/dijkstra_scheduler.sv
// rtl/dijkstra_scheduler.sv - request arbiter, node fetch, engine launch and path streamer
//
// Build option: define DIJKSTRA_TIMEOUT_EN to add the WAIT watchdog (eng_clear pulse + status 10 beat).
//
// Ports:
//   clk, reset_n                      sole clock, asynchronous active-low reset
//   req_valid[1:0], req_ready[1:0]    two requesters; req_ready is the one-hot grant, only in IDLE
//   req_start_id, req_goal_id         {req1, req0} 16-bit node ids
//   node_addr, node_rdata             node RAM read port, data returns one cycle after the address
//   eng_start                         one-cycle engine launch pulse
//   eng_start_node, eng_goal_node     latched node_info records presented to the engine
//   eng_done, eng_success, eng_len    engine completion and result
//   eng_rd_idx, eng_rd_coord          engine path array read port (combinational read)
//   eng_clear                         one-cycle engine soft clear (watchdog expiry)
//   out_valid, out_ready, out_coord,
//   out_last, out_owner, out_status   result stream back to the served requester
//   busy                              high whenever the controller is not IDLE
module dijkstra_scheduler #(
    parameter int NODE_AW        = 8,
    parameter int MAX_PATH       = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [31:0]        req_start_id,
    input  logic [31:0]        req_goal_id,
    output logic [NODE_AW-1:0] node_addr,
    input  logic [271:0]       node_rdata,
    output logic               eng_start,
    output logic [271:0]       eng_start_node,
    output logic [271:0]       eng_goal_node,
    input  logic               eng_done,
    input  logic               eng_success,
    input  logic [15:0]        eng_len,
    output logic [6:0]         eng_rd_idx,
    input  logic [31:0]        eng_rd_coord,
    output logic               eng_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_coord,
    output logic               out_last,
    output logic               out_owner,
    output logic [1:0]         out_status,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_S, S_FETCH_G, S_LATCH, S_START, S_WAIT, S_STREAM
    } state_t;

    state_t             state;
    logic               rr;
    logic               gnt;
    logic [NODE_AW-1:0] goal_addr;
    logic [6:0]         last_idx;
    logic               path_beat;
    logic               len_ok;
    logic               timeout_hit;

    // When both requesters are valid the round-robin pointer decides;
    // otherwise the single valid requester wins.
    assign gnt       = (&req_valid) ? rr : req_valid[1];
    assign req_ready = (state == S_IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign len_ok    = (eng_len != 16'd0) && (eng_len <= 16'(MAX_PATH));

    // Error beats carry a zero coordinate; path beats come straight from the
    // engine array, which stays stable while eng_rd_idx is held.
    assign out_coord = path_beat ? eng_rd_coord : 32'd0;

    // Only the low NODE_AW bits of a node id address the RAM.
    logic unused_id_bits;
    assign unused_id_bits = ^{req_start_id[15:NODE_AW], req_start_id[31:16+NODE_AW],
                              req_goal_id[15:NODE_AW], req_goal_id[31:16+NODE_AW]};

`ifdef DIJKSTRA_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] wait_cnt;

    // eng_done in the terminal-count cycle takes priority over the timeout.
    assign timeout_hit = (state == S_WAIT) && !eng_done && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= 20'd0;
            eng_clear <= 1'b0;
        end else begin
            eng_clear <= timeout_hit;
            if (state == S_START)
                wait_cnt <= 20'd0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 20'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign eng_clear   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            rr             <= 1'b0;
            busy           <= 1'b0;
            node_addr      <= '0;
            goal_addr      <= '0;
            eng_start      <= 1'b0;
            eng_start_node <= '0;
            eng_goal_node  <= '0;
            eng_rd_idx     <= 7'd0;
            last_idx       <= 7'd0;
            path_beat      <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_status     <= 2'b00;
            out_owner      <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        rr        <= ~gnt;
                        out_owner <= gnt;
                        node_addr <= gnt ? req_start_id[16 +: NODE_AW] : req_start_id[0 +: NODE_AW];
                        goal_addr <= gnt ? req_goal_id[16 +: NODE_AW]  : req_goal_id[0 +: NODE_AW];
                        busy      <= 1'b1;
                        state     <= S_FETCH_S;
                    end
                end
                S_FETCH_S: begin
                    node_addr <= goal_addr;
                    state     <= S_FETCH_G;
                end
                S_FETCH_G: begin
                    eng_start_node <= node_rdata;
                    state          <= S_LATCH;
                end
                S_LATCH: begin
                    eng_goal_node <= node_rdata;
                    eng_start     <= 1'b1;
                    state         <= S_START;
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        out_valid  <= 1'b1;
                        eng_rd_idx <= 7'd0;
                        state      <= S_STREAM;
                        if (eng_success && len_ok) begin
                            out_status <= 2'b00;
                            path_beat  <= 1'b1;
                            last_idx   <= eng_len[6:0] - 7'd1;
                            out_last   <= (eng_len[6:0] == 7'd1);
                        end else begin
                            out_status <= eng_success ? 2'b11 : 2'b01;
                            path_beat  <= 1'b0;
                            out_last   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        out_valid  <= 1'b1;
                        out_status <= 2'b10;
                        path_beat  <= 1'b0;
                        out_last   <= 1'b1;
                        state      <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            path_beat <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            eng_rd_idx <= eng_rd_idx + 7'd1;
                            out_last   <= ((eng_rd_idx + 7'd1) == last_idx);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dijkstra_scheduler.sv
// tb/tb_dijkstra_scheduler.sv - self-checking bench for dijkstra_scheduler
module tb_dijkstra_scheduler;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [31:0]  req_start_id, req_goal_id;
    logic [7:0]   node_addr;
    logic [271:0] node_rdata;
    logic         eng_start;
    logic [271:0] eng_start_node, eng_goal_node;
    logic         eng_done, eng_success;
    logic [15:0]  eng_len;
    logic [6:0]   eng_rd_idx;
    logic [31:0]  eng_rd_coord;
    logic         eng_clear;
    logic         out_valid, out_ready, out_last, out_owner, busy;
    logic [31:0]  out_coord;
    logic [1:0]   out_status;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] path_seed = 16'h0;
    bit model_rr;

    always #5 clk = ~clk;

    dijkstra_scheduler #(.NODE_AW(8), .MAX_PATH(100), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start_id(req_start_id), .req_goal_id(req_goal_id),
        .node_addr(node_addr), .node_rdata(node_rdata),
        .eng_start(eng_start), .eng_start_node(eng_start_node), .eng_goal_node(eng_goal_node),
        .eng_done(eng_done), .eng_success(eng_success), .eng_len(eng_len),
        .eng_rd_idx(eng_rd_idx), .eng_rd_coord(eng_rd_coord), .eng_clear(eng_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_coord(out_coord),
        .out_last(out_last), .out_owner(out_owner), .out_status(out_status), .busy(busy)
    );

    function automatic logic [271:0] rec(input logic [7:0] a);
        return {17{a, a ^ 8'hc3}};
    endfunction

    function automatic logic [31:0] coord_fn(input logic [15:0] s, input int i);
        return {16'(i * 37) + s, s ^ 16'(i << 4) ^ 16'h1234};
    endfunction

    // Node RAM with one-cycle read latency, engine path array with combinational read.
    always @(posedge clk) node_rdata <= rec(node_addr);
    assign eng_rd_coord = coord_fn(path_seed, int'(eng_rd_idx));

    task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", req_ready, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_clear", eng_clear, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_status", out_status, 0);
        check("rst_out_owner", out_owner, 0);
        check("rst_busy", busy, 0);
        check("rst_node_addr", node_addr, 0);
        check("rst_rd_idx", eng_rd_idx, 0);
        check("rst_start_node", eng_start_node, 0);
        check("rst_goal_node", eng_goal_node, 0);
        check("rst_out_coord", out_coord, 0);
    endtask

    // Runs one request from the accept cycle to the first IDLE cycle after the
    // last handshake. delay < 0 means the engine never answers.
    task automatic run_txn(input logic [1:0] valid, input logic [15:0] s0, input logic [15:0] g0,
                           input logic [15:0] s1, input logic [15:0] g1,
                           input bit succ, input logic [15:0] len, input int delay, input int bp,
                           input bit early, input logic [1:0] hold,
                           input bit exp_owner, input logic [1:0] exp_status, input int exp_beats);
        logic [15:0] sid, gid;
        logic [31:0] s_coord, exp_coord;
        logic s_last;
        bit stalled, rdy;
        int beat, guard;
        sid = exp_owner ? s1 : s0;
        gid = exp_owner ? g1 : g0;
        path_seed = 16'($urandom);
        req_valid = valid;
        req_start_id = {s1, s0};
        req_goal_id  = {g1, g0};
        #1;
        check("grant", req_ready, exp_owner ? 2'b10 : 2'b01);
        @(negedge clk);
        req_valid = hold;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            check("busy", busy, 1);
            check("eng_start_cyc", eng_start, (k == 4));
            check("no_grant_busy", req_ready, 0);
            if (k == 1) check("addr_start", node_addr, sid[7:0]);
            if (k == 2) check("addr_goal", node_addr, gid[7:0]);
            if (k == 2 && early) begin eng_done = 1; eng_success = 1; eng_len = 16'd2; end
            if (k == 3) eng_done = 0;
        end
        @(negedge clk);
        check("eng_start_off", eng_start, 0);
        check("start_rec", eng_start_node, rec(sid[7:0]));
        check("goal_rec", eng_goal_node, rec(gid[7:0]));
`ifdef DIJKSTRA_TIMEOUT_EN
        if (delay < 0) begin
            for (int w = 0; w < 16; w++) begin
                check("to_no_clear", eng_clear, 0);
                check("to_no_valid", out_valid, 0);
                @(negedge clk);
            end
            check("clear_pulse", eng_clear, 1);
            check("to_valid", out_valid, 1);
        end else
`endif
        begin
            for (int w = 0; w < delay; w++) begin
                check("wait_no_valid", out_valid, 0);
                check("wait_no_clear", eng_clear, 0);
                @(negedge clk);
            end
            eng_done = 1; eng_success = succ; eng_len = len;
            check("pre_done_valid", out_valid, 0);
            @(negedge clk);
            eng_done = 0; eng_success = 1'($urandom); eng_len = 16'($urandom);
            check("first_valid", out_valid, 1);
        end
        beat = 0; guard = 0; stalled = 0; s_coord = 0; s_last = 0;
        while (beat < exp_beats && guard < 4000) begin
            if (!out_valid) begin
                check("valid_drop", out_valid, 1);
                break;
            end
            if (stalled) begin
                check("stall_coord", out_coord, s_coord);
                check("stall_last", out_last, s_last);
            end
            exp_coord = (exp_status == 2'b00) ? coord_fn(path_seed, beat) : 32'd0;
            check("coord", out_coord, exp_coord);
            check("last", out_last, (beat == exp_beats - 1));
            check("status", out_status, exp_status);
            check("owner", out_owner, exp_owner);
            rdy = ($urandom_range(99) >= bp);
            out_ready = rdy;
            s_coord = out_coord; s_last = out_last; stalled = !rdy;
            if (rdy) beat++;
            @(negedge clk);
            guard++;
        end
        out_ready = 0;
        req_valid = 0;
        check("beat_count", beat, exp_beats);
        check("end_valid", out_valid, 0);
        check("end_busy", busy, 0);
        check("end_clear", eng_clear, 0);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] sid, gid;
        bit          succ;
        logic [15:0] len;
        int          delay, bp;
        bit          early;
        bit          exp_owner;
        logic [1:0]  exp_status;
        int          exp_beats;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit owner, succ;
        logic [1:0] v, st;
        logic [15:0] len;
        int beats, r;

        vecs[0] = '{2'b11, 16'h1203, 16'h1207, 1'b1, 16'd3,   0, 0,  1'b0, 1'b0, 2'b00, 3};
        vecs[1] = '{2'b11, 16'h0010, 16'h0020, 1'b1, 16'd2,   1, 0,  1'b0, 1'b1, 2'b00, 2};
        vecs[2] = '{2'b01, 16'h003a, 16'h0051, 1'b1, 16'd5,   2, 0,  1'b0, 1'b0, 2'b00, 5};
        vecs[3] = '{2'b10, 16'h0044, 16'h0099, 1'b0, 16'd7,   0, 20, 1'b1, 1'b1, 2'b01, 1};
        vecs[4] = '{2'b01, 16'h7f01, 16'h0002, 1'b1, 16'd101, 3, 0,  1'b0, 1'b0, 2'b11, 1};
        vecs[5] = '{2'b01, 16'h00aa, 16'h00bb, 1'b1, 16'd0,   0, 30, 1'b0, 1'b0, 2'b11, 1};
        vecs[6] = '{2'b11, 16'h0001, 16'h00fe, 1'b1, 16'd100, 0, 0,  1'b0, 1'b1, 2'b00, 100};
        vecs[7] = '{2'b10, 16'h0033, 16'h0034, 1'b1, 16'd1,   1, 0,  1'b0, 1'b1, 2'b00, 1};
        vecs[8] = '{2'b01, 16'h0080, 16'h0081, 1'b1, 16'd8,   0, 50, 1'b0, 1'b0, 2'b00, 8};
        vecs[9] = '{2'b11, 16'h00c0, 16'h00c4, 1'b1, 16'd4,   2, 25, 1'b0, 1'b1, 2'b00, 4};

        reset_n = 0; req_valid = 0; req_start_id = 0; req_goal_id = 0;
        eng_done = 0; eng_success = 0; eng_len = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset_n = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].valid, vecs[i].sid, vecs[i].gid,
                    vecs[i].sid ^ 16'h00ff, vecs[i].gid ^ 16'h00ff,
                    vecs[i].succ, vecs[i].len, vecs[i].delay, vecs[i].bp, vecs[i].early,
                    (i % 3 == 0) ? 2'b10 : 2'b00,
                    vecs[i].exp_owner, vecs[i].exp_status, vecs[i].exp_beats);

        // Reset while beat 2 of a 6-beat path is on the bus.
        path_seed = 16'h5555;
        req_valid = 2'b01; req_start_id = 32'h0000_0011; req_goal_id = 32'h0000_0012;
        @(negedge clk);
        req_valid = 0;
        repeat (4) @(negedge clk);
        eng_done = 1; eng_success = 1; eng_len = 16'd6;
        @(negedge clk);
        eng_done = 0;
        out_ready = 1;
        repeat (2) @(negedge clk);
        check("mid_idx", eng_rd_idx, 2);
        check("mid_coord", out_coord, coord_fn(16'h5555, 2));
        reset_n = 0;
        #1;
        check_reset_vals();
        out_ready = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        // Pointer is back at 0 after reset, so requester 0 wins the tie.
        run_txn(2'b11, 16'h0021, 16'h0022, 16'h0031, 16'h0032, 1'b1, 16'd3, 0, 0, 1'b0,
                2'b00, 1'b0, 2'b00, 3);
        model_rr = 1'b1;

        // Random requests against the reference rules.
        for (int t = 0; t < 25; t++) begin
            v = 2'($urandom_range(1, 3));
            owner = (v == 2'b11) ? model_rr : v[1];
            model_rr = !owner;
            succ = ($urandom_range(4) != 0);
            r = $urandom_range(9);
            len = (r == 0) ? 16'd0 : (r == 1) ? 16'(101 + $urandom_range(200)) : 16'($urandom_range(1, 12));
            st = !succ ? 2'b01 : (len == 0 || len > 100) ? 2'b11 : 2'b00;
            beats = (st == 2'b00) ? int'(len) : 1;
            run_txn(v, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    succ, len, $urandom_range(3), $urandom_range(60), 1'($urandom),
                    2'($urandom), owner, st, beats);
        end

`ifdef DIJKSTRA_TIMEOUT_EN
        owner = model_rr; model_rr = !owner;
        run_txn(2'b11, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 1'b1, 16'd3, -1, 0, 1'b0,
                2'b00, owner, 2'b10, 1);
        owner = model_rr; model_rr = !owner;
        run_txn(2'b11, 16'h0009, 16'h000a, 16'h000b, 16'h000c, 1'b1, 16'd3, 15, 0, 1'b0,
                2'b00, owner, 2'b00, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dijkstra_scheduler.md
# dijkstra_scheduler

Front-end controller for the pathfinding engine: arbitrates route requests from two requesters (0 = HPS bridge, 1 = cart UI), fetches start/goal `node_info` records (272 bits) from the node RAM, and launches the Dijkstra engine with a one-cycle start pulse. It waits for completion, then streams the path coordinates back to the winning requester over a valid/ready interface. It sits between the Avalon/UI request logic and the Dijkstra engine, and is the only block that drives the engine's start input.

## Interface
- `NODE_AW`, 8, node RAM address width; the low `NODE_AW` bits of a node id form the address.
- `MAX_PATH`, 100, engine path array depth.
- `TIMEOUT_CYCLES`, 1000000, watchdog limit in clocks; counter is 20 bits.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request.
- `req_ready`  out  2  one-hot grant; asserted only in IDLE.
- `req_start_id`  in  32  {req1, req0} 16-bit start node ids.
- `req_goal_id`  in  32  {req1, req0} 16-bit goal node ids.
- `node_addr`  out  NODE_AW  node RAM read address; data returns 1 cycle later.
- `node_rdata`  in  272  `node_info` record.
- `eng_start`  out  1  one-cycle engine start pulse.
- `eng_start_node`, `eng_goal_node`  out  272 each  latched records; held stable from START until the next request.
- `eng_done`  in  1  engine completion pulse.
- `eng_success`  in  1  engine found a path; qualified by `eng_done`.
- `eng_len`  in  16  path length; qualified by `eng_done`.
- `eng_rd_idx`  out  7  path array read index.
- `eng_rd_coord`  in  32  {x, y} at `eng_rd_idx`; combinational read.
- `eng_clear`  out  1  one-cycle engine soft clear.
- `out_valid`, `out_ready`  out/in  1  result stream handshake.
- `out_coord`  out  32  {x[15:0], y[15:0]}.
- `out_last`  out  1  final beat.
- `out_owner`  out  1  requester served.
- `out_status`  out  2  00 ok, 01 no path, 10 timeout, 11 bad length.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE → FETCH_S → FETCH_G → LATCH → START → WAIT → STREAM → IDLE.
- **IDLE:** grants a requester when any `req_valid` is high.
  - Round-robin pointer `rr` (reset 0) favours requester `rr` when both are valid.
  - After a grant, `rr` becomes the non-granted requester.
  - Accept captures the ids and the owner.
- **FETCH_S:** `node_addr` = start id.
- **FETCH_G:** `node_addr` = goal id; latch `node_rdata` into `eng_start_node`.
- **LATCH:** latch `node_rdata` into `eng_goal_node`.
- **START:** `eng_start` = 1 for exactly this cycle.
- **WAIT:** waits for `eng_done`, then branches:
  - `eng_success` = 1 and 1 ≤ `eng_len` ≤ MAX_PATH: enter STREAM with index 0, status 00.
  - `eng_success` = 0: emit one beat with `out_coord` = 0, `out_last` = 1, status 01.
  - `eng_success` = 1 and `eng_len` = 0 or `eng_len` > MAX_PATH: emit one beat with `out_coord` = 0, `out_last` = 1, status 11.
- **STREAM:**
  - `eng_rd_idx` = beat index; `out_coord` = `eng_rd_coord`.
  - The index advances on each `out_valid & out_ready`.
  - `out_last` = 1 at index `eng_len`−1; the handshake on the last beat returns to IDLE.
- `out_valid` and all payload fields stay stable while `out_ready` = 0.
- `out_owner` and `out_status` are constant across a response.

## Timing
- Reset values: `req_ready` = 0, `eng_start` = 0, `eng_clear` = 0, `out_valid` = 0, `out_last` = 0, `out_status` = 0, `out_owner` = 0, `busy` = 0. `node_addr`, `eng_rd_idx`, the latched records and `out_coord` are all 0. `rr` = 0.
- Accept cycle = cycle 0. `eng_start` is high in cycle 4 only. `busy` is high from cycle 1.
- First `out_valid` appears the cycle after `eng_done` is sampled.
- Throughput is 1 beat/clk with `out_ready` held high.
- A request arriving while busy waits; `req_ready` stays 0 and no request is dropped.
- `eng_done` outside WAIT is ignored.
- Reset mid-operation returns asynchronously to IDLE with all outputs at their reset values. There is no partial stream on exit.
- Back-to-back: IDLE can grant in the cycle after the last beat's handshake.

## Configuration
- **`DIJKSTRA_TIMEOUT_EN` defined:**
  - A 20-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES`−1 without `eng_done`: pulse `eng_clear` for 1 cycle and emit one beat with status 10, `out_last` = 1.
  - If `eng_done` arrives in the terminal-count cycle, `eng_done` wins and there is no timeout.
- **Undefined:** no counter; WAIT is unbounded; `eng_clear` is tied to 0.

## Test plan
- Requester 0 asks for ids 0x003a→0x0051; engine returns success with len 5 → `eng_start` in cycle 4 only, records match RAM, 5 beats in index order, last on beat 4, status 00, owner 0.
- Both requesters valid at once twice in succession from reset → first grant to 0, second to 1, and `req_ready` is never both high.
- Engine returns `eng_success` = 0 → single beat with coord 0, last = 1, status 01. Separate case: engine returns len = 101 → single beat with status 11.
- Random `out_ready` backpressure during an 8-beat path → payload stable while stalled, no beat lost or repeated, 8 handshakes total.
- Assert `reset_n` low during STREAM beat 2 → outputs at reset values immediately; a new request is served normally afterwards.
- With `DIJKSTRA_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, engine never signals done → `eng_clear` pulses after 16 WAIT cycles and a status-10 beat is emitted. Case 2: `eng_done` in cycle 15 → normal result instead.
